// File: rtl/qci_pkg.sv
// Shared definitions for the qhttp correction responder: handshake states,
// correction field layout and the default pair lifetime.
package qci_pkg;

  typedef enum logic [1:0] {
    OFFER_WAIT = 2'd0,
    OFFERED    = 2'd1,
    ISSUE      = 2'd2,
    RELEASE    = 2'd3
  } qci_state_e;

  localparam int QC_X_BIT        = 0;
  localparam int QC_Z_BIT        = 1;
  localparam int QC_QUBIT_LSB    = 2;
  localparam int T_COHERENCE_DEF = 1000;

  function automatic logic qc_is_identity(input logic [3:0] corr);
    return ~(corr[QC_X_BIT] | corr[QC_Z_BIT]);
  endfunction

endpackage

// File: rtl/epr_age_fifo.sv
// Circular FIFO of heralding timestamps, one entry per stored EPR pair.
// Push on full and pop on empty are ignored; callers arbitrate.
module epr_age_fifo #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [TS_W-1:0]          i_push_ts,
  input  logic                     i_pop,
  output logic [TS_W-1:0]          o_head_ts,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [TS_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign w_push    = i_push & ~o_full;
  assign w_pop     = i_pop & ~o_empty;
  assign o_head_ts = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_ts;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/qhttp_correction_responder.sv
// Quantum-side responder of the correction handshake: reserves a heralded EPR
// pair, offers it via quantum_ready, and forwards Pauli corrections.
module qhttp_correction_responder
  import qci_pkg::*;
#(
  parameter int EPR_DEPTH   = 8,
  parameter int T_COHERENCE = T_COHERENCE_DEF,
  parameter int TS_W        = 16,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         epr_herald,
  input  logic [3:0]                   quantum_correction,
  input  logic                         quantum_valid,
  output logic                         quantum_ready,
  output logic                         op_valid,
  output logic [1:0]                   op_qubit,
  output logic                         op_x,
  output logic                         op_z,
  output logic                         op_stale,
  input  logic                         op_ready,
  output logic [$clog2(EPR_DEPTH):0]   pairs_avail,
  output logic [CNT_W-1:0]             applied_count,
  output logic [CNT_W-1:0]             decohered_count,
  output logic [CNT_W-1:0]             dropped_count,
  output logic [CNT_W-1:0]             stale_count
);

  localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
  localparam logic [TS_W-1:0]  T_LIFE  = TS_W'(T_COHERENCE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  qci_state_e                   r_state;
  logic [TS_W-1:0]              r_ts;
  logic [TS_W-1:0]              r_resv_ts;
  logic                         r_ready;
  logic                         r_op_valid;
  logic [1:0]                   r_op_qubit;
  logic                         r_op_x;
  logic                         r_op_z;
  logic                         r_op_stale;
  logic [CNT_W-1:0]             r_applied;
  logic [CNT_W-1:0]             r_decohered;
  logic [CNT_W-1:0]             r_dropped;
  logic [CNT_W-1:0]             r_stale;

  logic [TS_W-1:0]              w_head_ts;
  logic [$clog2(EPR_DEPTH):0]   w_count;
  logic                         w_full;
  logic                         w_empty;
  logic [TS_W-1:0]              w_head_age;
  logic [TS_W-1:0]              w_resv_age;
  logic                         w_head_expired;
  logic                         w_resv_stale;
  logic                         w_reserve;
  logic                         w_pop;
  logic                         w_capture;
  logic                         w_op_fire;
  logic                         w_applied_inc;

  // Ages are modular differences, so timestamp wrap is harmless.
  assign w_head_age     = r_ts - w_head_ts;
  assign w_resv_age     = r_ts - r_resv_ts;
  assign w_head_expired = ~w_empty & (w_head_age >= T_LIFE);
  assign w_resv_stale   = (w_resv_age >= T_LIFE);
  assign w_reserve      = (r_state == OFFER_WAIT) & ~w_empty & ~w_head_expired & ~quantum_valid;
  assign w_pop          = w_head_expired | w_reserve;
  assign w_capture      = (r_state == OFFERED) & quantum_valid;
  assign w_op_fire      = (r_state == ISSUE) & r_op_valid & op_ready;
  assign w_applied_inc  = w_op_fire | (w_capture & qc_is_identity(quantum_correction));

  epr_age_fifo #(
    .DEPTH (EPR_DEPTH),
    .TS_W  (TS_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (epr_herald),
    .i_push_ts (r_ts),
    .i_pop     (w_pop),
    .o_head_ts (w_head_ts),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + TS_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= OFFER_WAIT;
      r_resv_ts  <= '0;
      r_ready    <= 1'b0;
      r_op_valid <= 1'b0;
      r_op_qubit <= 2'd0;
      r_op_x     <= 1'b0;
      r_op_z     <= 1'b0;
      r_op_stale <= 1'b0;
    end else begin
      case (r_state)
        OFFER_WAIT: begin
          if (w_reserve) begin
            r_resv_ts <= w_head_ts;
            r_ready   <= 1'b1;
            r_state   <= OFFERED;
          end
        end
        OFFERED: begin
          if (quantum_valid) begin
            r_ready    <= 1'b0;
            r_op_qubit <= quantum_correction[QC_QUBIT_LSB +: 2];
            r_op_x     <= quantum_correction[QC_X_BIT];
            r_op_z     <= quantum_correction[QC_Z_BIT];
            r_op_stale <= w_resv_stale;
            if (qc_is_identity(quantum_correction)) begin
              r_state <= RELEASE;
            end else begin
              r_op_valid <= 1'b1;
              r_state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (r_op_valid && op_ready) begin
            r_op_valid <= 1'b0;
            r_state    <= RELEASE;
          end
        end
        RELEASE: begin
          // Valid may still be high from the captured beat; wait it out.
          if (!quantum_valid) r_state <= OFFER_WAIT;
        end
        default: begin
          r_state    <= OFFER_WAIT;
          r_ready    <= 1'b0;
          r_op_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_applied   <= '0;
      r_decohered <= '0;
      r_dropped   <= '0;
      r_stale     <= '0;
    end else begin
      if (w_applied_inc && (r_applied != '1))             r_applied   <= r_applied + CNT_ONE;
      if (w_head_expired && (r_decohered != '1))          r_decohered <= r_decohered + CNT_ONE;
      if (epr_herald && w_full && (r_dropped != '1))      r_dropped   <= r_dropped + CNT_ONE;
      if (w_capture && w_resv_stale && (r_stale != '1))   r_stale     <= r_stale + CNT_ONE;
    end
  end

  assign quantum_ready   = r_ready;
  assign op_valid        = r_op_valid;
  assign op_qubit        = r_op_qubit;
  assign op_x            = r_op_x;
  assign op_z            = r_op_z;
  assign op_stale        = r_op_stale;
  assign pairs_avail     = w_count;
  assign applied_count   = r_applied;
  assign decohered_count = r_decohered;
  assign dropped_count   = r_dropped;
  assign stale_count     = r_stale;

endmodule

// File: tb/tb_qhttp_correction_responder.sv
// Scenario bench for qhttp_correction_responder; expected Pauli ops are queued
// when a correction is driven and checked when op_valid appears.
module tb_qhttp_correction_responder;

  localparam int DEPTH = 8;
  localparam int T_COH = 1000;
  localparam int TS_W  = 16;
  localparam int CNT_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [1:0] qubit;
    logic       x;
    logic       z;
    logic       stale;
  } op_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             epr_herald;
  logic [3:0]       quantum_correction;
  logic             quantum_valid;
  logic             quantum_ready;
  logic             op_valid;
  logic [1:0]       op_qubit;
  logic             op_x;
  logic             op_z;
  logic             op_stale;
  logic             op_ready;
  logic [CW-1:0]    pairs_avail;
  logic [CNT_W-1:0] applied_count;
  logic [CNT_W-1:0] decohered_count;
  logic [CNT_W-1:0] dropped_count;
  logic [CNT_W-1:0] stale_count;

  int  n_pass  = 0;
  int  n_total = 0;
  op_t exp_q[$];
  op_t obs;
  op_t exp_op;
  bit  seen;

  always #5 clk = ~clk;

  qhttp_correction_responder #(
    .EPR_DEPTH   (DEPTH),
    .T_COHERENCE (T_COH),
    .TS_W        (TS_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .epr_herald         (epr_herald),
    .quantum_correction (quantum_correction),
    .quantum_valid      (quantum_valid),
    .quantum_ready      (quantum_ready),
    .op_valid           (op_valid),
    .op_qubit           (op_qubit),
    .op_x               (op_x),
    .op_z               (op_z),
    .op_stale           (op_stale),
    .op_ready           (op_ready),
    .pairs_avail        (pairs_avail),
    .applied_count      (applied_count),
    .decohered_count    (decohered_count),
    .dropped_count      (dropped_count),
    .stale_count        (stale_count)
  );

  function automatic op_t model_op(input logic [3:0] c, input logic stale);
    op_t o;
    o.qubit = c[3:2];
    o.x     = c[0];
    o.z     = c[1];
    o.stale = stale;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    epr_herald         = 1'b0;
    quantum_valid      = 1'b0;
    quantum_correction = 4'd0;
    op_ready           = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Drive one non-identity correction and wait (bounded) for op_valid.
  task automatic drive_capture(input logic [3:0] c, input logic stale, output op_t o, output bit ok);
    int k;
    quantum_valid      = 1'b1;
    quantum_correction = c;
    exp_q.push_back(model_op(c, stale));
    tick();
    k = 0;
    while (!op_valid && k < 8) begin
      tick();
      k++;
    end
    ok = op_valid;
    o  = '{qubit: op_qubit, x: op_x, z: op_z, stale: op_stale};
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({quantum_ready, op_valid, op_qubit, op_x, op_z, op_stale, pairs_avail} !== '0)
      $display("FAIL reset_outputs: got %b required 0", {quantum_ready, op_valid, op_qubit, op_x, op_z, op_stale, pairs_avail});
    else n_pass++;
    n_total++;
    if ({applied_count, decohered_count, dropped_count, stale_count} !== '0)
      $display("FAIL reset_counters: got %h required 0", {applied_count, decohered_count, dropped_count, stale_count});
    else n_pass++;
  endtask

  task automatic test_pauli();
    do_reset();
    op_ready   = 1'b1;
    epr_herald = 1'b1;
    tick();
    epr_herald = 1'b0;
    n_total++;
    if (quantum_ready !== 1'b0) $display("FAIL ready_early: got %b required 0", quantum_ready); else n_pass++;
    tick();
    n_total++;
    if (quantum_ready !== 1'b1) $display("FAIL ready_latency: got %b required 1", quantum_ready); else n_pass++;
    tick();
    tick();
    drive_capture(4'b0111, 1'b0, obs, seen);
    exp_op = exp_q.pop_front();
    n_total++;
    if (!seen || obs !== exp_op) $display("FAIL pauli_op: got %b (seen %0d) required %b", obs, seen, exp_op); else n_pass++;
    tick();
    n_total++;
    if (op_valid !== 1'b0 || applied_count !== 16'd1)
      $display("FAIL pauli_accept: got op_valid %b applied %0d required 0/1", op_valid, applied_count);
    else n_pass++;
    epr_herald = 1'b1;
    tick();
    epr_herald = 1'b0;
    tick();
    tick();
    n_total++;
    if (quantum_ready !== 1'b0 || pairs_avail !== 4'd1)
      $display("FAIL ready_held_low: got ready %b avail %0d required 0/1", quantum_ready, pairs_avail);
    else n_pass++;
    quantum_valid = 1'b0;
    tick();
    tick();
    n_total++;
    if (quantum_ready !== 1'b1 || pairs_avail !== 4'd0)
      $display("FAIL ready_rerise: got ready %b avail %0d required 1/0", quantum_ready, pairs_avail);
    else n_pass++;
  endtask

  task automatic test_identity();
    do_reset();
    op_ready   = 1'b1;
    epr_herald = 1'b1;
    tick();
    epr_herald = 1'b0;
    tick();
    quantum_valid      = 1'b1;
    quantum_correction = 4'b1000;
    tick();
    n_total++;
    if (op_valid !== 1'b0 || applied_count !== 16'd1 || quantum_ready !== 1'b0)
      $display("FAIL identity: got op_valid %b applied %0d ready %b required 0/1/0", op_valid, applied_count, quantum_ready);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (op_valid !== 1'b0 || applied_count !== 16'd1)
      $display("FAIL identity_release: got op_valid %b applied %0d required 0/1", op_valid, applied_count);
    else n_pass++;
    quantum_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_stale();
    do_reset();
    op_ready   = 1'b1;
    epr_herald = 1'b1;
    tick();
    epr_herald = 1'b0;
    tick();
    repeat (T_COH + 10) tick();
    n_total++;
    if (quantum_ready !== 1'b1 || decohered_count !== 16'd0)
      $display("FAIL reserved_exempt: got ready %b decohered %0d required 1/0", quantum_ready, decohered_count);
    else n_pass++;
    drive_capture(4'b0001, 1'b1, obs, seen);
    exp_op = exp_q.pop_front();
    n_total++;
    if (!seen || obs !== exp_op) $display("FAIL stale_op: got %b (seen %0d) required %b", obs, seen, exp_op); else n_pass++;
    n_total++;
    if (stale_count !== 16'd1 || decohered_count !== 16'd0)
      $display("FAIL stale_count: got stale %0d decohered %0d required 1/0", stale_count, decohered_count);
    else n_pass++;
    tick();
    quantum_valid = 1'b0;
    tick();
  endtask

  task automatic test_decohere();
    do_reset();
    epr_herald = 1'b1;
    tick();
    epr_herald = 1'b0;
    tick();
    drive_capture(4'b0011, 1'b0, obs, seen);
    exp_op = exp_q.pop_front();
    n_total++;
    if (!seen || obs !== exp_op) $display("FAIL issue_op: got %b (seen %0d) required %b", obs, seen, exp_op); else n_pass++;
    epr_herald = 1'b1;
    repeat (3) tick();
    epr_herald = 1'b0;
    repeat (1200) tick();
    n_total++;
    if (decohered_count !== 16'd3 || pairs_avail !== 4'd0 || op_valid !== 1'b1)
      $display("FAIL decohere: got decohered %0d avail %0d op_valid %b required 3/0/1", decohered_count, pairs_avail, op_valid);
    else n_pass++;
    op_ready = 1'b1;
    tick();
    quantum_valid = 1'b0;
    repeat (5) tick();
    n_total++;
    if (quantum_ready !== 1'b0 || applied_count !== 16'd1)
      $display("FAIL decohere_release: got ready %b applied %0d required 0/1", quantum_ready, applied_count);
    else n_pass++;
  endtask

  // 11 heralds: one is reserved, eight fill the FIFO, the last two are dropped.
  task automatic test_overflow();
    do_reset();
    epr_herald = 1'b1;
    repeat (DEPTH + 3) tick();
    epr_herald = 1'b0;
    tick();
    n_total++;
    if (pairs_avail !== 4'(DEPTH) || dropped_count !== 16'd2 || quantum_ready !== 1'b1)
      $display("FAIL overflow: got avail %0d dropped %0d ready %b required %0d/2/1", pairs_avail, dropped_count, quantum_ready, DEPTH);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    op_ready = 1'b1;
    repeat (65515) tick();
    epr_herald = 1'b1;
    tick();
    tick();
    epr_herald = 1'b0;
    repeat (40) tick();
    n_total++;
    if (decohered_count !== 16'd0 || pairs_avail !== 4'd1 || quantum_ready !== 1'b1)
      $display("FAIL wrap: got decohered %0d avail %0d ready %b required 0/1/1", decohered_count, pairs_avail, quantum_ready);
    else n_pass++;
    drive_capture(4'b0101, 1'b0, obs, seen);
    exp_op = exp_q.pop_front();
    n_total++;
    if (!seen || obs !== exp_op) $display("FAIL wrap_op: got %b (seen %0d) required %b", obs, seen, exp_op); else n_pass++;
    tick();
    quantum_valid = 1'b0;
    tick();
  endtask

  task automatic test_midreset();
    do_reset();
    epr_herald = 1'b1;
    tick();
    tick();
    epr_herald = 1'b0;
    drive_capture(4'b0110, 1'b0, obs, seen);
    exp_op = exp_q.pop_front();
    n_total++;
    if (!seen || obs !== exp_op || pairs_avail !== 4'd1)
      $display("FAIL pre_reset: got %b avail %0d (seen %0d) required %b avail 1", obs, pairs_avail, seen, exp_op);
    else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({quantum_ready, op_valid, op_qubit, op_x, op_z, op_stale, pairs_avail, applied_count} !== '0)
      $display("FAIL async_reset: got %b required 0", {quantum_ready, op_valid, op_qubit, op_x, op_z, op_stale, pairs_avail, applied_count});
    else n_pass++;
    quantum_valid = 1'b0;
    op_ready      = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    n_total++;
    if (quantum_ready !== 1'b0 || pairs_avail !== 4'd0 || op_valid !== 1'b0 || applied_count !== 16'd0)
      $display("FAIL post_reset: got ready %b avail %0d op_valid %b applied %0d required 0/0/0/0", quantum_ready, pairs_avail, op_valid, applied_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pauli();
    test_identity();
    test_stale();
    test_decohere();
    test_overflow();
    test_midreset();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
